// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// States, widths and the DIV/DIVU op codes.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [2*DIV_WIDTH-1:0] DIV_RESULT_ZERO = '0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step.
// Compare runs one bit wider than the operands.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // shift, trial subtract, keep or restore
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    qbit     = (shifted >= {1'b0, divisor});
    rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/div_iter.sv
// Iterative DIV/DIVU for the EX stage.
// One quotient bit per clock, result held until start drops.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t state, state_d;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic             qbit;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] q_fin, q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .dvd_next (dvd_nx),
    .qbit     (qbit)
  );

  // operand magnitudes and final sign fix
  always_comb begin
    abs1  = opdata1;
    abs2  = opdata2;
    if (signed_div && opdata1[WIDTH-1])
      abs1 = -opdata1;
    if (signed_div && opdata2[WIDTH-1])
      abs2 = -opdata2;
    q_fin = {dvd_nx[WIDTH-1:1], qbit};
    q_fix = neg_q ? -q_fin : q_fin;
    r_fix = neg_r ? -rem_nx : rem_nx;
  end

  // next-state decode, annul overrides
  always_comb begin
    state_d = state;
    unique case (state)
      DIV_IDLE:
        if (start)
          state_d = (opdata2 == '0) ? DIV_ZERO
                                    : DIV_ON;
      DIV_ZERO: state_d = DIV_END;
      DIV_ON:
        if (cnt == LAST)
          state_d = DIV_END;
      DIV_END:
        if (!start)
          state_d = DIV_IDLE;
    endcase
    if (annul)
      state_d = DIV_IDLE;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= DIV_IDLE;
    else
      state <= state_d;
  end

  // datapath, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else if (annul) begin
      result <= '0;
      ready  <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE:
          if (start && opdata2 != '0) begin
            dvd   <= abs1;
            dvs   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= signed_div &
                     (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_r <= signed_div & opdata1[WIDTH-1];
          end
        DIV_ZERO: result <= '0;
        DIV_ON: begin
          rem <= rem_nx;
          dvd <= dvd_nx | WIDTH'(qbit);
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            result <= {r_fix, q_fix};
        end
        DIV_END:
          if (!start) begin
            ready  <= 1'b0;
            result <= '0;
          end else begin
            ready  <= 1'b1;
          end
      endcase
    end
  end

endmodule
